i2s_rx: RTL

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx.sv | 117 +++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S receiver, 16-bit stereo pairs on clk32; define I2S_RX_FIFO_EN for a 4-entry pair FIFO instead of one holding register
module i2s_rx #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        i2s_bck,
  input  logic        i2s_ws,
  input  logic        i2s_din,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        audio_valid,
  input  logic        audio_ready,
  output logic        locked,
  output logic        overrun,
  output logic        frame_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {UNLOCKED, CAPTURE} state_t;
  state_t state, state_nx;
  logic [1:0] bck_q, ws_q, din_q;
  logic bck_d, ws_prev, pend;
  logic [4:0] bit_cnt;
  logic [15:0] sr, left_w, word;
  logic [TW-1:0] to_cnt;
  logic bck_rise, ws_chg, done, short_w, push, timeout;
  always_comb begin
    bck_rise = bck_q[1] & ~bck_d;
    ws_chg = ws_q[1] != ws_prev;
    word = bit_cnt[4] ? sr : {sr[14:0], din_q[1]};
    done = state == CAPTURE && bck_rise && ws_chg;
    short_w = done && bit_cnt < 5'd15;
    push = done && !short_w && ws_prev && pend;
    timeout = state == CAPTURE && !bck_rise && to_cnt == TW'(TIMEOUT - 1);
    state_nx = state == UNLOCKED ? (bck_rise && ws_chg ? CAPTURE : UNLOCKED) : (timeout ? UNLOCKED : CAPTURE);
  end
  always_ff @(posedge clk32)
    state <= reset ? UNLOCKED : state_nx;
  assign locked = state == CAPTURE;
  always_ff @(posedge clk32) begin
    if (reset) begin
      bck_q <= '0;
      ws_q <= '0;
      din_q <= '0;
      bck_d <= 1'b0;
      ws_prev <= 1'b0;
      to_cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      left_w <= '0;
      pend <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bck_q <= {bck_q[0], i2s_bck};
      ws_q <= {ws_q[0], i2s_ws};
      din_q <= {din_q[0], i2s_din};
      bck_d <= bck_q[1];
      if (bck_rise) ws_prev <= ws_q[1];
      to_cnt <= (state == CAPTURE && !bck_rise) ? to_cnt + 1'b1 : '0;
      // the bit sampled on the ws-change edge belongs to the slot just ending
      if (state == UNLOCKED || (bck_rise && ws_chg)) bit_cnt <= '0;
      else if (bck_rise && !bit_cnt[4]) begin
        sr <= word;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (timeout || short_w || push) pend <= 1'b0;
      else if (done && !ws_prev) begin
        pend <= 1'b1;
        left_w <= word;
      end
      frame_err <= short_w;
    end
  end
`ifdef I2S_RX_FIFO_EN
  logic [31:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic pop, wr;
  always_comb begin
    pop = audio_valid && audio_ready;
    wr = push && (!cnt[2] || pop);
  end
  assign audio_valid = cnt != 3'd0;
  assign {audio_l, audio_r} = mem[rp];
  always_ff @(posedge clk32) begin
    if (reset) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr) begin
        mem[wp] <= {left_w, word};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + 3'(wr) - 3'(pop);
      if (push && !wr) overrun <= 1'b1;
    end
  end
`else
  logic [31:0] hold;
  assign {audio_l, audio_r} = hold;
  always_ff @(posedge clk32) begin
    if (reset) begin
      hold <= '0;
      audio_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (push) hold <= {left_w, word};
      if (push && audio_valid && !audio_ready) overrun <= 1'b1;
      audio_valid <= push || (audio_valid && !audio_ready);
    end
  end
`endif
endmodule
